mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/musa_mem_pkg.sv | 20 ++
 rtl/mau_lane_ops.sv | 39 +++
 rtl/mem_access_unit.sv | 150 +++++++++++++++
 tb/tb_mem_access_unit.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/musa_mem_pkg.sv
// Shared types for the memory access unit: size encodings, FSM states, default widths.
package musa_mem_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_WAIT = 2'b01,
    ST_RMW_MERGE = 2'b10
  } state_e;

endpackage

// File: rtl/mau_lane_ops.sv
// Combinational little-endian lane logic: load extract/extend and sub-word store merge.
module mau_lane_ops
  import musa_mem_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = rdata[{offset, 3'b000} +: 8];
    half_v     = offset[1] ? rdata[31:16] : rdata[15:0];
    load_data  = rdata;
    merge_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{is_signed & byte_v[7]}}, byte_v};
        merge_data = rdata;
        merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{is_signed & half_v[15]}}, half_v};
        merge_data = offset[1] ? {wdata[15:0], rdata[15:0]} : {rdata[31:16], wdata[15:0]};
      end
      default: begin
        load_data  = rdata;
        merge_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a 1-cycle-latency word memory; sub-word stores use read-modify-write.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN: reject misaligned/reserved-size requests with misalign_err.
module mem_access_unit
  import musa_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              misalign_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_read,
  output logic              mem_write
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          off_q, off_d;
  size_e               size_q, size_d;
  logic                signed_q, signed_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  size_e               req_size_n;
  logic [1:0]          req_off_n;
  logic                trap;
  logic [DATA_W-1:0]   load_data, merge_data;

  // Reserved size folds to word; offsets that cannot address a lane are aligned down.
  always_comb begin
    req_size_n = size_e'(req_size);
    req_off_n  = req_addr[1:0];
    case (size_e'(req_size))
      SZ_BYTE: req_off_n = req_addr[1:0];
      SZ_HALF: req_off_n = {req_addr[1], 1'b0};
      default: begin
        req_size_n = SZ_WORD;
        req_off_n  = 2'b00;
      end
    endcase
  end

  always_comb begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    case (size_e'(req_size))
      SZ_BYTE: trap = 1'b0;
      SZ_HALF: trap = req_addr[0];
      SZ_WORD: trap = |req_addr[1:0];
      default: trap = 1'b1;
    endcase
`else
    trap = 1'b0;
`endif
  end

  mau_lane_ops u_lane_ops (
    .size       (size_q),
    .offset     (off_q),
    .is_signed  (signed_q),
    .rdata      (mem_data_out),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    misalign_err = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (trap) begin
              misalign_err = 1'b1;
            end else if (req_store && req_size_n == SZ_WORD) begin
              mem_write   = 1'b1;
              mem_addr    = req_addr[ADDR_W+1:2];
              mem_data_in = req_wdata;
            end else begin
              mem_read = 1'b1;
              mem_addr = req_addr[ADDR_W+1:2];
              addr_d   = req_addr[ADDR_W+1:2];
              off_d    = req_off_n;
              size_d   = req_size_n;
              signed_d = req_signed;
              wdata_d  = req_wdata;
              state_d  = req_store ? ST_RMW_MERGE : ST_LOAD_WAIT;
            end
          end
        end
        ST_LOAD_WAIT: begin
          mem_addr   = addr_q;
          resp_valid = 1'b1;
          resp_rdata = load_data;
          state_d    = ST_IDLE;
        end
        ST_RMW_MERGE: begin
          mem_addr    = addr_q;
          mem_write   = 1'b1;
          mem_data_in = merge_data;
          state_d     = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      off_q    <= '0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      off_q    <= off_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural word memory and lane-arithmetic reference model.
module tb_mem_access_unit;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_store = 1'b0, req_signed = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW+1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid, misalign_err, mem_read, mem_write;
  logic [31:0]   resp_rdata, mem_data_in;
  logic [31:0]   mem_data_out = '0;
  logic [AW-1:0] mem_addr;

  logic [31:0] mem     [0:2047];
  logic [31:0] ref_mem [0:2047];

  int checks = 0;
  int failures = 0;

  logic          acc_ready, acc_read, acc_write, acc_mis;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_data;
  logic          c2_ready, c2_rv, c2_write, c2_read;
  logic [AW-1:0] c2_addr;
  logic [31:0]   c2_data, c2_rdata;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign_err(misalign_err), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (mem_read && mem_write) begin
        failures++;
        $display("FAIL strobe_exclusive: mem_read=%0b mem_write=%0b required not both 1", mem_read, mem_write);
      end
    end
  end

  function automatic logic model_trap(input logic [AW+1:0] a, input logic [1:0] sz);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int lane_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [AW+1:0] a, input logic [1:0] sz);
    int n = lane_bytes(sz);
    int o = int'(a[1:0]);
    return o - (o % n);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [AW+1:0] a,
                                            input logic [1:0] sz, input logic sg);
    int n = lane_bytes(sz);
    longint v;
    if (n == 4) return w;
    v = (longint'(w) >> (8 * lane_off(a, sz))) & ((64'sd1 << (8 * n)) - 1);
    if (sg && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [AW+1:0] a,
                                             input logic [1:0] sz, input logic [31:0] d);
    int n = lane_bytes(sz);
    longint mask, v;
    mask = ((64'sd1 << (8 * n)) - 1) << (8 * lane_off(a, sz));
    v = (longint'(w) & ~mask) | ((longint'(d) << (8 * lane_off(a, sz))) & mask);
    return v[31:0];
  endfunction

  // Presents one request, records the acceptance cycle and the following cycle.
  task automatic issue_op(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [AW+1:0] a, input logic [31:0] d, input logic two);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    @(negedge clk);
    acc_ready = req_ready; acc_read = mem_read; acc_write = mem_write; acc_mis = misalign_err;
    acc_addr = mem_addr; acc_data = mem_data_in;
    @(posedge clk); #1;
    req_valid = two; req_store = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = (AW+2)'($urandom); req_wdata = $urandom;
    @(negedge clk);
    c2_ready = req_ready; c2_rv = resp_valid; c2_write = mem_write; c2_read = mem_read;
    c2_addr = mem_addr; c2_data = mem_data_in; c2_rdata = resp_rdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_addr = 13'h0014; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, misalign_err, mem_read, mem_write} !== 5'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b required 00000",
               {req_ready, resp_valid, misalign_err, mem_read, mem_write});
    end
    checks++;
    if ({mem_addr, mem_data_in} !== '0) begin
      failures++;
      $display("FAIL reset_addr_data: got addr=%h data=%h required 0/0", mem_addr, mem_data_in);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, misalign_err, mem_read, mem_write} !== 5'b10000) begin
      failures++;
      $display("FAIL idle_after_reset: got %b required 10000",
               {req_ready, resp_valid, misalign_err, mem_read, mem_write});
    end
    checks++;
    if (mem[5] !== ref_mem[5]) begin
      failures++;
      $display("FAIL reset_no_write: mem[5]=%h required %h", mem[5], ref_mem[5]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    mem[5] = 32'h8899AABB; ref_mem[5] = 32'h8899AABB;
    issue_op(1'b0, 2'd0, 1'b1, 13'h0015, 32'h0, 1'b1);
    checks++;
    if ({acc_read, c2_rv, c2_rdata} !== {2'b11, 32'hFFFFFFAA}) begin
      failures++;
      $display("FAIL load_sbyte: read=%b rv=%b rdata=%h required 1 1 FFFFFFAA", acc_read, c2_rv, c2_rdata);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL resp_pulse: resp_valid=%b one cycle later, required 0", resp_valid);
    end
    @(posedge clk); #1;
    issue_op(1'b0, 2'd1, 1'b0, 13'h0016, 32'h0, 1'b1);
    checks++;
    if ({c2_rv, c2_rdata} !== {1'b1, 32'h00008899}) begin
      failures++;
      $display("FAIL load_uhalf: rv=%b rdata=%h required 1 00008899", c2_rv, c2_rdata);
    end
    issue_op(1'b1, 2'd0, 1'b0, 13'h0017, 32'h11223344, 1'b1);
    checks++;
    if ({acc_read, acc_write, c2_ready, c2_write, c2_addr, c2_data} !== {4'b1001, 11'd5, 32'h4499AABB}) begin
      failures++;
      $display("FAIL store_byte_rmw: rd=%b wr=%b rdy2=%b wr2=%b addr2=%h data2=%h required 1 0 0 1 005 4499AABB",
               acc_read, acc_write, c2_ready, c2_write, c2_addr, c2_data);
    end
    checks++;
    if (mem[5] !== 32'h4499AABB) begin
      failures++;
      $display("FAIL store_byte_mem: mem[5]=%h required 4499AABB", mem[5]);
    end
    ref_mem[5] = 32'h4499AABB;
    issue_op(1'b1, 2'd2, 1'b0, 13'h1FFC, 32'hDEADBEEF, 1'b0);
    checks++;
    if ({acc_write, acc_read, acc_addr, acc_data} !== {2'b10, 11'h7FF, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL store_word_top: wr=%b rd=%b addr=%h data=%h required 1 0 7FF DEADBEEF",
               acc_write, acc_read, acc_addr, acc_data);
    end
    ref_mem[2047] = 32'hDEADBEEF;
    issue_op(1'b0, 2'd2, 1'b1, 13'h1FFC, 32'h0, 1'b1);
    checks++;
    if ({c2_rv, c2_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL load_word_top: rv=%b rdata=%h required 1 DEADBEEF", c2_rv, c2_rdata);
    end
  endtask

  task automatic test_misalign();
    issue_op(1'b0, 2'd1, 1'b0, 13'h0015, 32'h0, !model_trap(13'h0015, 2'd1));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    checks++;
    if ({acc_mis, acc_read, acc_write, c2_rv} !== 4'b1000) begin
      failures++;
      $display("FAIL misalign_half_trap: mis/rd/wr/rv=%b required 1000", {acc_mis, acc_read, acc_write, c2_rv});
    end
`else
    checks++;
    if ({acc_mis, acc_read, c2_rv, c2_rdata} !== {3'b011, 32'h0000AABB}) begin
      failures++;
      $display("FAIL misalign_half_align: mis=%b rd=%b rv=%b rdata=%h required 0 1 1 0000AABB",
               acc_mis, acc_read, c2_rv, c2_rdata);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      logic st, sg, trap, isword, two;
      logic [1:0] sz;
      logic [AW-1:0] w;
      logic [AW+1:0] a;
      logic [31:0] d, exp_ld, exp_st;
      st = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom); d = $urandom;
      w = ($urandom_range(0, 3) == 0) ? AW'(2047) : AW'($urandom_range(0, 15));
      a = {w, 2'($urandom)};
      trap = model_trap(a, sz);
      isword = sz[1];
      two = !trap && !(st && isword);
      exp_ld = model_load(ref_mem[w], a, sz, sg);
      exp_st = model_store(ref_mem[w], a, sz, d);
      issue_op(st, sz, sg, a, d, two);
      checks++;
      if ({acc_ready, acc_read, acc_write, acc_mis} !== {1'b1, two, !trap && st && isword, trap}) begin
        failures++;
        $display("FAIL rand_accept[%0d]: rdy/rd/wr/mis=%b required %b", i,
                 {acc_ready, acc_read, acc_write, acc_mis}, {1'b1, two, !trap && st && isword, trap});
      end
      if (!trap) begin
        checks++;
        if (acc_addr !== w) begin
          failures++;
          $display("FAIL rand_addr[%0d]: mem_addr=%h required %h", i, acc_addr, w);
        end
      end
      if (two) begin
        checks++;
        if ({c2_ready, c2_rv, c2_write, c2_read, c2_addr} !== {1'b0, !st, st, 1'b0, w}) begin
          failures++;
          $display("FAIL rand_busy[%0d]: rdy/rv/wr/rd=%b addr=%h required %b %h", i,
                   {c2_ready, c2_rv, c2_write, c2_read}, c2_addr, {1'b0, !st, st, 1'b0}, w);
        end
        checks++;
        if ((st ? c2_data : c2_rdata) !== (st ? exp_st : exp_ld)) begin
          failures++;
          $display("FAIL rand_data[%0d]: st=%b got %h required %h", i, st,
                   st ? c2_data : c2_rdata, st ? exp_st : exp_ld);
        end
      end else begin
        checks++;
        if ({c2_ready, c2_rv, c2_write, c2_read} !== 4'b1000) begin
          failures++;
          $display("FAIL rand_single[%0d]: rdy/rv/wr/rd=%b required 1000", i, {c2_ready, c2_rv, c2_write, c2_read});
        end
        if (st && !trap) begin
          checks++;
          if (acc_data !== d) begin
            failures++;
            $display("FAIL rand_wdata[%0d]: mem_data_in=%h required %h", i, acc_data, d);
          end
        end
      end
      if (st && !trap) ref_mem[w] = exp_st;
      checks++;
      if (mem[w] !== ref_mem[w]) begin
        failures++;
        $display("FAIL rand_mem[%0d]: mem[%h]=%h required %h", i, w, mem[w], ref_mem[w]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic          st [8];
    logic [1:0]    sz [8];
    logic          sg [8];
    logic [AW+1:0] ad [8];
    logic [31:0]   dd [8];
    logic [31:0]   exp_q [$];
    int idx = 0, cyc = 0, exp_cyc = 1;
    for (int i = 0; i < 8; i++) begin
      st[i] = 1'($urandom); sz[i] = 2'($urandom); sg[i] = 1'($urandom);
      ad[i] = {AW'($urandom_range(0, 3)), 2'($urandom)}; dd[i] = $urandom;
      if (i < 7)
        exp_cyc += (model_trap(ad[i], sz[i]) || (st[i] && sz[i][1])) ? 1 : 2;
    end
    req_valid = 1'b1; req_store = st[0]; req_size = sz[0]; req_signed = sg[0]; req_addr = ad[0]; req_wdata = dd[0];
    while (idx < 8 && cyc < 100) begin
      @(negedge clk);
      if (resp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra_resp: rdata=%h with no load outstanding", resp_rdata);
        end else if (resp_rdata !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_resp: rdata=%h required %h", resp_rdata, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (req_ready) begin
        logic [AW-1:0] w;
        w = ad[idx][AW+1:2];
        if (!model_trap(ad[idx], sz[idx])) begin
          if (st[idx]) ref_mem[w] = model_store(ref_mem[w], ad[idx], sz[idx], dd[idx]);
          else exp_q.push_back(model_load(ref_mem[w], ad[idx], sz[idx], sg[idx]));
        end
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (idx < 8) begin
        req_store = st[idx]; req_size = sz[idx]; req_signed = sg[idx]; req_addr = ad[idx]; req_wdata = dd[idx];
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (cyc != exp_cyc) begin
      failures++;
      $display("FAIL b2b_cycles: took %0d cycles required %0d", cyc, exp_cyc);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        checks++;
        if (exp_q.size() == 0 || resp_rdata !== exp_q[0]) begin
          failures++;
          $display("FAIL b2b_drain: rdata=%h pending=%0d", resp_rdata, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_missing_resp: %0d responses never arrived", exp_q.size());
    end
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (mem[w] !== ref_mem[w]) begin
        failures++;
        $display("FAIL b2b_mem: mem[%0d]=%h required %h", w, mem[w], ref_mem[w]);
      end
    end
  endtask

  task automatic test_abort_reset();
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 13'h000A; req_wdata = 32'hCAFE5A5A;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1) begin
      failures++;
      $display("FAIL abort_rmw_read: mem_read=%b required 1", mem_read);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_write, resp_valid, req_ready} !== 3'b000) begin
      failures++;
      $display("FAIL abort_rmw_write: wr/rv/rdy=%b required 000", {mem_write, resp_valid, req_ready});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_write} !== 2'b10) begin
      failures++;
      $display("FAIL abort_release: rdy/wr=%b required 10", {req_ready, mem_write});
    end
    checks++;
    if (mem[2] !== ref_mem[2]) begin
      failures++;
      $display("FAIL abort_mem: mem[2]=%h required %h", mem[2], ref_mem[2]);
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd0; req_addr = 13'h0008;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_load: resp_valid=%b required 0", resp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_directed();
    test_misalign();
    test_random();
    test_back_to_back();
    test_abort_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
